// File: rtl/jtcps1_gfx_rom_xlat.sv
// CPS1 graphics ROM address translator: maps linear layer addresses
// through the board PAL bank mapper, with a one-entry mapping cache.
module jtcps1_gfx_rom_xlat #(
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          req,
   input  logic [2:0]    layer,
   input  logic [19:0]   addr,
   output logic [DW-1:0] data,
   output logic          ok,
   output logic          map_en,
   output logic [2:0]    map_layer,
   output logic [9:0]    map_cin,
   input  logic [3:0]    map_offset,
   input  logic [3:0]    map_mask,
   output logic [19:0]   rom_addr,
   output logic          rom_cs,
   input  logic          rom_ok,
   input  logic [DW-1:0] rom_data
);

   typedef enum logic [2:0] {
      IDLE,
      MAP,
      LOOK,
      READ,
      DONE
   } state_t;

   state_t        state_q, state_d;
   logic          first_q, first_d;
   logic [DW-1:0] data_q, data_d;
   logic          ok_q, ok_d;
   logic          map_en_q, map_en_d;
   logic [2:0]    map_layer_q, map_layer_d;
   logic [9:0]    map_cin_q, map_cin_d;
   logic [19:0]   rom_addr_q, rom_addr_d;
   logic          rom_cs_q, rom_cs_d;
   logic [15:0]   lo_q, lo_d;
   logic          vld_q, vld_d;
   logic [2:0]    c_layer_q, c_layer_d;
   logic [9:0]    c_tag_q, c_tag_d;
   logic [3:0]    c_off_q, c_off_d;
   logic [3:0]    c_mask_q, c_mask_d;
   logic          hit;

   assign hit = vld_q && (c_layer_q == layer) && (c_tag_q == addr[19:10]);

   always_comb begin
      state_d     = state_q;
      first_d     = first_q;
      data_d      = data_q;
      ok_d        = ok_q;
      map_en_d    = map_en_q;
      map_layer_d = map_layer_q;
      map_cin_d   = map_cin_q;
      rom_addr_d  = rom_addr_q;
      rom_cs_d    = rom_cs_q;
      lo_d        = lo_q;
      vld_d       = vld_q;
      c_layer_d   = c_layer_q;
      c_tag_d     = c_tag_q;
      c_off_d     = c_off_q;
      c_mask_d    = c_mask_q;
      unique case (state_q)
         IDLE: begin
            if (req) begin
               lo_d = addr[15:0];
               if (hit) begin
                  rom_addr_d = {(addr[19:16] & c_mask_q) | c_off_q,
                                addr[15:0]};
                  rom_cs_d   = 1'b1;
                  first_d    = 1'b1;
                  state_d    = READ;
               end else begin
                  map_en_d    = 1'b1;
                  map_layer_d = layer;
                  map_cin_d   = addr[19:10];
                  state_d     = MAP;
               end
            end
         end
         MAP: begin
            map_en_d = 1'b0;
            state_d  = LOOK;
         end
         LOOK: begin
            vld_d      = 1'b1;
            c_layer_d  = map_layer_q;
            c_tag_d    = map_cin_q;
            c_off_d    = map_offset;
            c_mask_d   = map_mask;
            rom_addr_d = {(map_cin_q[9:6] & map_mask) | map_offset, lo_q};
            rom_cs_d   = 1'b1;
            first_d    = 1'b1;
            state_d    = READ;
         end
         READ: begin
            // first cycle may still see the previous access's ok
            first_d = 1'b0;
            if (!first_q && rom_ok) begin
               data_d   = rom_data;
               ok_d     = 1'b1;
               rom_cs_d = 1'b0;
               state_d  = DONE;
            end
         end
         DONE: begin
            ok_d    = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (flush) vld_d = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         first_q     <= 1'b0;
         data_q      <= '0;
         ok_q        <= 1'b0;
         map_en_q    <= 1'b0;
         map_layer_q <= '0;
         map_cin_q   <= '0;
         rom_addr_q  <= '0;
         rom_cs_q    <= 1'b0;
         lo_q        <= '0;
         vld_q       <= 1'b0;
         c_layer_q   <= '0;
         c_tag_q     <= '0;
         c_off_q     <= '0;
         c_mask_q    <= '0;
      end else begin
         state_q     <= state_d;
         first_q     <= first_d;
         data_q      <= data_d;
         ok_q        <= ok_d;
         map_en_q    <= map_en_d;
         map_layer_q <= map_layer_d;
         map_cin_q   <= map_cin_d;
         rom_addr_q  <= rom_addr_d;
         rom_cs_q    <= rom_cs_d;
         lo_q        <= lo_d;
         vld_q       <= vld_d;
         c_layer_q   <= c_layer_d;
         c_tag_q     <= c_tag_d;
         c_off_q     <= c_off_d;
         c_mask_q    <= c_mask_d;
      end
   end

   assign data      = data_q;
   assign ok        = ok_q;
   assign map_en    = map_en_q;
   assign map_layer = map_layer_q;
   assign map_cin   = map_cin_q;
   assign rom_addr  = rom_addr_q;
   assign rom_cs    = rom_cs_q;

endmodule

// File: tb/tb_jtcps1_gfx_rom_xlat.sv
// Bench for jtcps1_gfx_rom_xlat: directed scenarios plus random
// traffic against a one-entry mapping cache reference model.
module tb_jtcps1_gfx_rom_xlat;

   logic        clk = 1'b0;
   logic        rst, flush, req;
   logic [2:0]  layer;
   logic [19:0] addr;
   logic [31:0] data;
   logic        ok, map_en;
   logic [2:0]  map_layer;
   logic [9:0]  map_cin;
   logic [3:0]  map_offset, map_mask;
   logic [19:0] rom_addr;
   logic        rom_cs, rom_ok;
   logic [31:0] rom_data;
   logic [3:0]  mo, mm;

   int npass = 0;
   int ntotal = 0;

   // reference cache
   bit         c_valid;
   int         c_layer, c_tag, c_off, c_mask;

   typedef struct {
      int          n_map;
      logic [9:0]  cin;
      logic [2:0]  lay;
      int          cs_lat;
      logic [19:0] ra;
      int          ok_lat;
      int          exp_ok;
      logic [31:0] dat;
      logic [31:0] exp_dat;
      bit          cs_gap;
      logic        cs_at_ok;
      bit          to;
      logic        ok_after;
   } obs_t;

   jtcps1_gfx_rom_xlat #(.DW(32)) dut (
      .clk(clk), .rst(rst), .flush(flush), .req(req),
      .layer(layer), .addr(addr), .data(data), .ok(ok),
      .map_en(map_en), .map_layer(map_layer), .map_cin(map_cin),
      .map_offset(map_offset), .map_mask(map_mask),
      .rom_addr(rom_addr), .rom_cs(rom_cs), .rom_ok(rom_ok),
      .rom_data(rom_data)
   );

   always #5 clk = ~clk;

   // PAL mapper: registers the bank selected by mo/mm when enabled
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         map_offset <= 4'h0;
         map_mask   <= 4'hF;
      end else if (map_en) begin
         map_offset <= mo;
         map_mask   <= mm;
      end
   end

   function automatic void model(input int l, input int a, input int o,
                                 input int m, output bit miss,
                                 output logic [19:0] ea);
      miss = !(c_valid && c_layer == l && c_tag == a / 1024);
      if (miss) begin
         c_valid = 1;
         c_layer = l;
         c_tag   = a / 1024;
         c_off   = o;
         c_mask  = m;
      end
      ea = 20'(((((a / 65536) & c_mask) | c_off) * 65536) + a % 65536);
   endfunction

   task automatic txn(input logic [2:0] l, input logic [19:0] a,
                      input logic [3:0] o, input logic [3:0] m,
                      input bit stale, input int d, input bit fl_read,
                      input bit fl_look, output obs_t r);
      r.n_map = 0; r.cs_lat = -1; r.ok_lat = -1; r.cs_gap = 0;
      r.cin = 'x; r.lay = 'x; r.ra = 'x; r.dat = 'x; r.cs_at_ok = 'x;
      mo = o; mm = m;
      req = 1; layer = l; addr = a;
      rom_ok = stale; rom_data = $urandom; r.exp_dat = rom_data;
      for (int c = 1; c <= 40 && r.ok_lat < 0; c++) begin
         @(posedge clk); #1;
         flush = 0;
         if (map_en) begin
            r.n_map++; r.cin = map_cin; r.lay = map_layer;
         end
         if (ok) begin
            r.ok_lat = c; r.dat = data; r.cs_at_ok = rom_cs;
         end else begin
            if (r.cs_lat < 0 && rom_cs) begin
               r.cs_lat = c; r.ra = rom_addr;
               if (fl_read) flush = 1;
            end else if (r.cs_lat >= 0 && !rom_cs) r.cs_gap = 1;
            if (fl_look && c == 2) flush = 1;
            if (r.cs_lat >= 0) begin
               if (stale && c == r.cs_lat + 1) begin
                  rom_data = $urandom; r.exp_dat = rom_data;
               end
               if (!stale && c == r.cs_lat + d) begin
                  rom_ok = 1; rom_data = $urandom; r.exp_dat = rom_data;
               end
            end
         end
      end
      r.to = (r.ok_lat < 0);
      r.exp_ok = stale ? r.cs_lat + 2 : r.cs_lat + d + 1;
      req = 0; rom_ok = 0; flush = 0;
      @(posedge clk); #1;
      r.ok_after = ok;
   endtask

   task automatic test_reset;
      rst = 1; flush = 0; req = 0; layer = 0; addr = 0;
      rom_ok = 0; rom_data = 0; mo = 0; mm = 4'hF;
      c_valid = 0;
      repeat (2) @(posedge clk);
      #1;
      ntotal++;
      if ({data, ok, map_en, map_layer, map_cin, rom_addr, rom_cs} !== '0)
         $display("FAIL reset_outputs got %h/%b/%b/%h/%h/%h/%b want all 0",
                  data, ok, map_en, map_layer, map_cin, rom_addr, rom_cs);
      else npass++;
      rst = 0;
      @(posedge clk); #1;
   endtask

   task automatic test_miss_passthrough;
      obs_t r; bit miss; logic [19:0] ea;
      model(1, 'h12345, 0, 15, miss, ea);
      txn(3'd1, 20'h12345, 4'h0, 4'hF, 0, 1, 0, 0, r);
      ntotal++;
      if (r.n_map !== 1 || r.cin !== 10'h048 || r.lay !== 3'd1)
         $display("FAIL miss_map got n=%0d cin=%h lay=%0d want 1/048/1",
                  r.n_map, r.cin, r.lay);
      else npass++;
      ntotal++;
      if (r.cs_lat !== 3 || r.ra !== 20'h12345)
         $display("FAIL miss_cs got lat=%0d ra=%h want 3/12345",
                  r.cs_lat, r.ra);
      else npass++;
      ntotal++;
      if (r.to || r.ok_lat !== 5 || r.dat !== r.exp_dat)
         $display("FAIL miss_ok got lat=%0d dat=%h want 5/%h",
                  r.ok_lat, r.dat, r.exp_dat);
      else npass++;
      ntotal++;
      if (r.ok_after !== 0 || r.cs_gap || r.cs_at_ok !== 0)
         $display("FAIL miss_pulse got ok_after=%b gap=%b cs=%b want 0/0/0",
                  r.ok_after, r.cs_gap, r.cs_at_ok);
      else npass++;
   endtask

   task automatic test_hit;
      obs_t r; bit miss; logic [19:0] ea;
      model(1, 'h12377, 5, 0, miss, ea);
      txn(3'd1, 20'h12377, 4'h5, 4'h0, 0, 2, 0, 0, r);
      ntotal++;
      if (r.n_map !== 0 || r.cs_lat !== 1 || r.ra !== 20'h12377)
         $display("FAIL hit got n=%0d lat=%0d ra=%h want 0/1/12377",
                  r.n_map, r.cs_lat, r.ra);
      else npass++;
      ntotal++;
      if (r.to || r.ok_lat !== 4 || r.dat !== r.exp_dat)
         $display("FAIL hit_ok got lat=%0d dat=%h want 4/%h",
                  r.ok_lat, r.dat, r.exp_dat);
      else npass++;
      model(1, 'h12745, 0, 15, miss, ea);
      txn(3'd1, 20'h12745, 4'h0, 4'hF, 0, 1, 0, 0, r);
      ntotal++;
      if (r.n_map !== 1 || r.cin !== 10'h049 || r.cs_lat !== 3 ||
          r.ra !== ea)
         $display("FAIL hit_newregion got n=%0d cin=%h lat=%0d ra=%h want 1/049/3/%h",
                  r.n_map, r.cin, r.cs_lat, r.ra, ea);
      else npass++;
   endtask

   task automatic test_offset_mask;
      obs_t r; bit miss; logic [19:0] ea;
      model(2, 'h7ABCD, 8, 3, miss, ea);
      txn(3'd2, 20'h7ABCD, 4'h8, 4'h3, 0, 1, 0, 0, r);
      ntotal++;
      if (r.n_map !== 1 || r.ra !== 20'hBABCD || r.dat !== r.exp_dat)
         $display("FAIL offset_mask got n=%0d ra=%h want 1/babcd",
                  r.n_map, r.ra);
      else npass++;
   endtask

   task automatic test_stale_ok;
      obs_t r; bit miss; logic [19:0] ea;
      model(2, 'h7AB00, 0, 15, miss, ea);
      txn(3'd2, 20'h7AB00, 4'h0, 4'hF, 1, 1, 0, 0, r);
      ntotal++;
      if (r.cs_lat !== 1 || r.ra !== 20'hBAB00)
         $display("FAIL stale_cs got lat=%0d ra=%h want 1/bab00",
                  r.cs_lat, r.ra);
      else npass++;
      ntotal++;
      if (r.to || r.ok_lat !== 3 || r.dat !== r.exp_dat)
         $display("FAIL stale_ok got lat=%0d dat=%h want 3/%h",
                  r.ok_lat, r.dat, r.exp_dat);
      else npass++;
   endtask

   task automatic test_flush_read;
      obs_t r; bit miss; logic [19:0] ea;
      model(2, 'h7ABFF, 0, 15, miss, ea);
      txn(3'd2, 20'h7ABFF, 4'h0, 4'hF, 0, 1, 1, 0, r);
      c_valid = 0;
      ntotal++;
      if (r.n_map !== 0 || r.ra !== 20'hBABFF || r.to ||
          r.dat !== r.exp_dat)
         $display("FAIL flush_read got n=%0d ra=%h to=%b want 0/babff/0",
                  r.n_map, r.ra, r.to);
      else npass++;
      model(2, 'h7AB11, 1, 15, miss, ea);
      txn(3'd2, 20'h7AB11, 4'h1, 4'hF, 0, 1, 0, 0, r);
      ntotal++;
      if (r.n_map !== 1 || r.ra !== 20'h7AB11)
         $display("FAIL flush_refetch got n=%0d ra=%h want 1/7ab11",
                  r.n_map, r.ra);
      else npass++;
   endtask

   task automatic test_flush_look;
      obs_t r; bit miss; logic [19:0] ea;
      model(4, 'h00400, 3, 0, miss, ea);
      txn(3'd4, 20'h00400, 4'h3, 4'h0, 0, 1, 0, 1, r);
      c_valid = 0;
      ntotal++;
      if (r.n_map !== 1 || r.ra !== 20'h30400)
         $display("FAIL flush_look got n=%0d ra=%h want 1/30400",
                  r.n_map, r.ra);
      else npass++;
      model(4, 'h00411, 3, 0, miss, ea);
      txn(3'd4, 20'h00411, 4'h3, 4'h0, 0, 1, 0, 0, r);
      ntotal++;
      if (r.n_map !== 1 || r.ra !== 20'h30411)
         $display("FAIL flush_look_refetch got n=%0d ra=%h want 1/30411",
                  r.n_map, r.ra);
      else npass++;
   endtask

   task automatic test_random;
      obs_t r; bit miss; logic [19:0] ea;
      int l, cin, a, o, m, d;
      bit st;
      int cins[4] = '{'h048, 'h049, 'h3FF, 'h000};
      l = 1; cin = 'h048;
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 1) == 0) begin
            l = $urandom_range(0, 4);
            cin = cins[$urandom_range(0, 3)];
         end
         if ($urandom_range(0, 7) == 0) begin
            flush = 1;
            @(posedge clk); #1;
            flush = 0;
            c_valid = 0;
         end
         a = cin * 1024 + $urandom_range(0, 1023);
         o = $urandom_range(0, 15);
         m = $urandom_range(0, 15);
         d = $urandom_range(1, 3);
         st = 1'($urandom_range(0, 1));
         model(l, a, o, m, miss, ea);
         txn(3'(l), 20'(a), 4'(o), 4'(m), st, d, 0, 0, r);
         ntotal++;
         if (r.n_map !== (miss ? 1 : 0) || r.cs_lat !== (miss ? 3 : 1))
            $display("FAIL rnd%0d_map got n=%0d lat=%0d want miss=%0d",
                     i, r.n_map, r.cs_lat, miss);
         else npass++;
         ntotal++;
         if (r.ra !== ea)
            $display("FAIL rnd%0d_addr got %h want %h", i, r.ra, ea);
         else npass++;
         ntotal++;
         if (r.to || r.ok_lat !== r.exp_ok || r.dat !== r.exp_dat ||
             r.ok_after !== 0 || r.cs_gap || r.cs_at_ok !== 0)
            $display("FAIL rnd%0d_ok got lat=%0d dat=%h want %0d/%h",
                     i, r.ok_lat, r.dat, r.exp_ok, r.exp_dat);
         else npass++;
      end
   endtask

   task automatic test_reset_mid;
      obs_t r; bit miss; logic [19:0] ea;
      mo = 0; mm = 4'hF;
      req = 1; layer = 3; addr = 20'h50123; rom_ok = 0;
      for (int c = 0; c < 10 && !rom_cs; c++) begin
         @(posedge clk); #1;
      end
      req = 0;
      ntotal++;
      if (rom_cs !== 1'b1)
         $display("FAIL rstmid_reach got rom_cs=%b want 1", rom_cs);
      else npass++;
      rst = 1; #1;
      ntotal++;
      if ({rom_cs, ok, map_en} !== 3'b000)
         $display("FAIL rstmid_outputs got cs/ok/en=%b%b%b want 000",
                  rom_cs, ok, map_en);
      else npass++;
      @(posedge clk); #1;
      rst = 0;
      c_valid = 0;
      @(posedge clk); #1;
      model(3, 'h50155, 0, 15, miss, ea);
      txn(3'd3, 20'h50155, 4'h0, 4'hF, 0, 1, 0, 0, r);
      ntotal++;
      if (r.n_map !== 1 || r.cs_lat !== 3 || r.ra !== 20'h50155)
         $display("FAIL rstmid_refetch got n=%0d lat=%0d ra=%h want 1/3/50155",
                  r.n_map, r.cs_lat, r.ra);
      else npass++;
   endtask

   initial begin
      test_reset;
      test_miss_passthrough;
      test_hit;
      test_offset_mask;
      test_stale_ok;
      test_flush_read;
      test_flush_look;
      test_random;
      test_reset_mid;
      $display("%0d/%0d checks passed", npass, ntotal);
      $finish;
   end

endmodule
